// File: rtl/fft_result_reader.sv
// fft_result_reader: sweeps the four FFT result banks in point order
// and presents the real-part words as a valid/ready stream.
module fft_result_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  output logic [ADDR_W-1:0] oADDR_RD_0,
  output logic [ADDR_W-1:0] oADDR_RD_1,
  output logic [ADDR_W-1:0] oADDR_RD_2,
  output logic [ADDR_W-1:0] oADDR_RD_3,
  input  logic [DATA_W-1:0] iDATA_RE_0,
  input  logic [DATA_W-1:0] iDATA_RE_1,
  input  logic [DATA_W-1:0] iDATA_RE_2,
  input  logic [DATA_W-1:0] iDATA_RE_3,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W+1:0] oINDEX,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oLAST,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int N_W = ADDR_W + 2;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [N_W-1:0] N_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_W-1:0]    rd_n;
  logic [CW-1:0]     cnt;
  logic              issue;
  logic              push;
  logic              pop;
  logic              empty;
  logic [RD_LAT-1:0] pv;
  logic [N_W-1:0]    pidx [RD_LAT];
  logic [N_W-1:0]    tail_idx;
  logic [DATA_W-1:0] bank_d;
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [N_W-1:0]    mem_i [FIFO_DEPTH];
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head_d;
  logic [N_W-1:0]    head_i;

  // cnt covers reads in flight plus FIFO entries, so a free
  // credit always means a free FIFO slot when the data lands
  assign issue    = (state == READ) && (cnt < CW'(FIFO_DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign pop      = !empty && iREADY;
  assign push     = pv[RD_LAT-1];
  assign tail_idx = pidx[RD_LAT-1];
  assign head_d   = mem_d[rd_ptr[PW-1:0]];
  assign head_i   = mem_i[rd_ptr[PW-1:0]];

  assign oADDR_RD_0 = rd_n[ADDR_W-1:0];
  assign oADDR_RD_1 = rd_n[ADDR_W-1:0];
  assign oADDR_RD_2 = rd_n[ADDR_W-1:0];
  assign oADDR_RD_3 = rd_n[ADDR_W-1:0];

  assign oVALID = !empty;
  assign oDATA  = empty ? '0 : head_d;
  assign oINDEX = empty ? '0 : head_i;
  assign oLAST  = !empty && (head_i == N_LAST);
  assign oBUSY  = (state != IDLE);
  assign oDONE  = (state == DONE);

  // state register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state; DRAIN ends as the final entry leaves the FIFO
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (iSTART) state_nxt = READ;
      READ:    if (issue && rd_n == N_LAST) state_nxt = DRAIN;
      DRAIN:   if (cnt == CW'(pop)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // issue counter, held at the last point so it never wraps
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      rd_n <= '0;
    end else if (state == IDLE && iSTART) begin
      rd_n <= '0;
    end else if (issue && rd_n != N_LAST) begin
      rd_n <= rd_n + 1'b1;
    end
  end

  // credit counter: +1 per issued read, -1 per popped beat
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) cnt <= '0;
    else        cnt <= cnt + CW'(issue) - CW'(pop);
  end

  // valid bits matching the RAM read latency
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      pv <= '0;
    end else begin
      pv[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
    end
  end

  // point index travelling alongside the valid bits
  always_ff @(posedge iCLK) begin
    pidx[0] <= rd_n;
    for (int i = 1; i < RD_LAT; i++) pidx[i] <= pidx[i-1];
  end

  // pick the bank addressed by the top two index bits
  always_comb begin
    bank_d = iDATA_RE_0;
    unique case (tail_idx[N_W-1:ADDR_W])
      2'd0:    bank_d = iDATA_RE_0;
      2'd1:    bank_d = iDATA_RE_1;
      2'd2:    bank_d = iDATA_RE_2;
      2'd3:    bank_d = iDATA_RE_3;
      default: bank_d = iDATA_RE_0;
    endcase
  end

  // FIFO storage
  always_ff @(posedge iCLK) begin
    if (push) begin
      mem_d[wr_ptr[PW-1:0]] <= bank_d;
      mem_i[wr_ptr[PW-1:0]] <= tail_idx;
    end
  end

  // FIFO pointers, cleared so a reset drops all queued beats
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
